// File: rtl/space_invaders_pkg.sv
// Shared constants, missile state encoding and fixed-point helpers for the
// player-missile datapath.
package space_invaders_pkg;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FP_SHIFT               = $clog2(FIXED_POINT_MULTIPLIER);
  localparam int SCREEN_WIDTH           = 640;
  localparam int SCREEN_HEIGHT          = 480;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } missile_state_e;

  // Fixed point to pixels, truncating toward zero so negative positions
  // round the same way as positive ones.
  function automatic logic signed [31:0] to_pixels(input logic signed [31:0] fp);
    logic signed [31:0] mag;
    mag = (fp < 0) ? -fp : fp;
    mag = mag >>> FP_SHIFT;
    return (fp < 0) ? -mag : mag;
  endfunction

endpackage

// File: rtl/missile_cooldown_timer.sv
// Frame-counting down-counter for the missile cooldown. done is asserted on
// the tick where the count is 1, or at once when loaded with zero.
module missile_cooldown_timer #(
  parameter int LOAD_VALUE = 15,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic resetN,
  input  logic load,
  input  logic tick,
  output logic done
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= CNT_W'(LOAD_VALUE);
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0) || ((r_count == CNT_W'(1)) && tick);

endmodule

// File: rtl/missile_move_collision.sv
// Player missile: launch from ship centre, per-frame upward motion in 1/64 px,
// retire on hit or top boundary, then frame cooldown. Macro MISSILE_AUTOFIRE_EN
// drops the release-between-shots (armed) requirement.
module missile_move_collision
  import space_invaders_pkg::*;
#(
  parameter int Y_SPEED         = 384,
  parameter int SHIP_WIDTH      = 64,
  parameter int MISSILE_WIDTH   = 4,
  parameter int SPAWN_Y         = 400,
  parameter int TOP_BOUNDARY    = 0,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               fireKey,
  input  logic signed [10:0] shipTopLeftX,
  input  logic               hitCollision,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               missileActive,
  output logic               shotFired
);

  missile_state_e     r_state;
  logic signed [31:0] r_y_fp;

  logic signed [31:0] w_spawn_x_fp;
  logic signed [31:0] w_y_next_fp;
  logic signed [31:0] w_y_next_px;
  logic               w_retire;
  logic               w_launch;
  logic               w_enter_cooldown;
  logic               w_cd_tick;
  logic               w_cd_done;

  assign w_spawn_x_fp = (32'(shipTopLeftX) + 32'(SHIP_WIDTH / 2) - 32'(MISSILE_WIDTH / 2))
                        * FIXED_POINT_MULTIPLIER;
  assign w_y_next_fp  = r_y_fp - Y_SPEED;
  assign w_y_next_px  = to_pixels(w_y_next_fp);
  assign w_retire     = (w_y_next_px < TOP_BOUNDARY);

`ifdef MISSILE_AUTOFIRE_EN
  assign w_launch = (r_state == IDLE) && startOfFrame && fireKey;
`else
  logic r_armed;

  assign w_launch = (r_state == IDLE) && startOfFrame && fireKey && r_armed;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_armed <= 1'b1;
    end else if (!fireKey) begin
      r_armed <= 1'b1;
    end else if (w_launch) begin
      r_armed <= 1'b0;
    end
  end
`endif

  // A hit takes priority over the frame step, so Y is never moved on that cycle.
  assign w_enter_cooldown = (r_state == FLYING) && (hitCollision || (startOfFrame && w_retire));
  assign w_cd_tick        = (r_state == COOLDOWN) && startOfFrame;

  missile_cooldown_timer #(
    .LOAD_VALUE (COOLDOWN_FRAMES),
    .CNT_W      (16)
  ) u_cooldown (
    .clk    (clk),
    .resetN (resetN),
    .load   (w_enter_cooldown),
    .tick   (w_cd_tick),
    .done   (w_cd_done)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= IDLE;
      r_y_fp        <= SPAWN_Y * FIXED_POINT_MULTIPLIER;
      topLeftX      <= '0;
      topLeftY      <= 11'(SPAWN_Y);
      missileActive <= 1'b0;
      shotFired     <= 1'b0;
    end else begin
      shotFired <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_state       <= FLYING;
            r_y_fp        <= SPAWN_Y * FIXED_POINT_MULTIPLIER;
            topLeftX      <= 11'(to_pixels(w_spawn_x_fp));
            topLeftY      <= 11'(SPAWN_Y);
            missileActive <= 1'b1;
            shotFired     <= 1'b1;
          end
        end
        FLYING: begin
          if (w_enter_cooldown) begin
            r_state       <= COOLDOWN;
            missileActive <= 1'b0;
          end else if (startOfFrame) begin
            r_y_fp   <= w_y_next_fp;
            topLeftY <= 11'(w_y_next_px);
          end
        end
        COOLDOWN: begin
          if (w_cd_done) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state       <= IDLE;
          missileActive <= 1'b0;
        end
      endcase
    end
  end

endmodule
